// File: rtl/neighbor_info_fifo_writer_if.sv
// rtl/neighbor_info_fifo_writer_if.sv - Edge-PE request channels and neighbor-info FIFO write port
interface neighbor_info_fifo_writer_if #(
  parameter int NUM_EDGE_PE = 4,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16
);
  logic                          flush;
  logic [NUM_EDGE_PE-1:0]        pe_valid;
  logic [NUM_EDGE_PE*DATA_W-1:0] pe_data;
  logic [NUM_EDGE_PE-1:0]        pe_ready;
  logic                          fifo_wfull;
  logic                          fifo_winc;
  logic [DATA_W-1:0]             fifo_wdata;
  logic                          busy;
  logic [CNT_W-1:0]              push_cnt;
  logic [CNT_W-1:0]              stall_cnt;

  // master is the surrounding system (PE array + FIFO), slave is the writer
  modport master (
    output flush, pe_valid, pe_data, fifo_wfull,
    input  pe_ready, fifo_winc, fifo_wdata, busy, push_cnt, stall_cnt
  );

  modport slave (
    input  flush, pe_valid, pe_data, fifo_wfull,
    output pe_ready, fifo_winc, fifo_wdata, busy, push_cnt, stall_cnt
  );
endinterface

// File: rtl/neighbor_info_fifo_writer.sv
// rtl/neighbor_info_fifo_writer.sv - One-deep per-channel hold buffers, round-robin drained into the neighbor-info FIFO
module neighbor_info_fifo_writer #(
  parameter int NUM_EDGE_PE = 4,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16
) (
  input logic                        wclk,
  input logic                        rst,
  neighbor_info_fifo_writer_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_EDGE_PE);

  logic [NUM_EDGE_PE-1:0] hold_vld;
  logic [DATA_W-1:0]      hold_data [NUM_EDGE_PE];
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant;
  logic [CNT_W-1:0]       push_cnt;
  logic [CNT_W-1:0]       stall_cnt;
  logic                   any_vld;
  logic                   live;
  logic                   push;
  logic [NUM_EDGE_PE-1:0] accept;

  assign any_vld = |hold_vld;
  assign live    = !bus.flush && !rst;
  assign push    = any_vld && !bus.fifo_wfull && live;
  // Ready depends only on registered state, never on pe_valid
  assign bus.pe_ready = ~hold_vld & {NUM_EDGE_PE{live}};
  assign accept       = bus.pe_valid & bus.pe_ready;

  // Scan downward so the lowest offset from rr_ptr wins; index wraps for free
  always_comb begin
    grant = rr_ptr;
    for (int k = NUM_EDGE_PE - 1; k >= 0; k--) begin
      if (hold_vld[rr_ptr + PTR_W'(k)]) grant = rr_ptr + PTR_W'(k);
    end
  end

  assign bus.fifo_winc  = push;
  assign bus.fifo_wdata = push ? hold_data[grant] : '0;
  assign bus.busy       = any_vld && !rst;
  assign bus.push_cnt   = push_cnt;
  assign bus.stall_cnt  = stall_cnt;

  always_ff @(posedge wclk) begin
    if (rst) begin
      hold_vld  <= '0;
      rr_ptr    <= '0;
      push_cnt  <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NUM_EDGE_PE; i++) hold_data[i] <= '0;
    end else begin
      if (any_vld && bus.fifo_wfull && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.flush) begin
        hold_vld <= '0;
      end else begin
        for (int i = 0; i < NUM_EDGE_PE; i++) begin
          if (accept[i]) begin
            hold_vld[i]  <= 1'b1;
            hold_data[i] <= bus.pe_data[i*DATA_W +: DATA_W];
          end
        end
        // The granted slot is held, so its ready is low and no accept collides here
        if (push) begin
          hold_vld[grant] <= 1'b0;
          rr_ptr          <= grant + PTR_W'(1);
          if (push_cnt != '1) push_cnt <= push_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule
